// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state encodings, opcode/funct
// constants, datapath select codes and the Moore output decode. ILLEGAL_TRAP_EN enables the TRAP state.
package mc_ctrl_fsm_pkg;

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_EX_R = 4'd2,
        S_WB_R = 4'd3,
        S_EX_I = 4'd4,
        S_WB_I = 4'd5,
        S_MA   = 4'd6,
        S_MRD  = 4'd7,
        S_MWB  = 4'd8,
        S_MWR  = 4'd9,
        S_BEQ  = 4'd10,
        S_JMP  = 4'd11,
        S_TRAP = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
`ifdef ILLEGAL_TRAP_EN
    localparam logic [1:0] PCSRC_TRAP   = 2'b11;
`endif

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
    } ctrl_t;

    // Registered Moore outputs for the state being entered; the fetch strobes are qualified by mem_ready elsewhere.
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_IF: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.pc_source = PCSRC_ALU;
            end
            S_ID:   c.alu_src_b = SRCB_IMM_SH;
            S_EX_R: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_B;
            end
            S_WB_R: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            S_EX_I, S_MA: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_WB_I: c.reg_write = 1'b1;
            S_MRD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            S_MWR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_B;
                c.pc_source     = PCSRC_ALUOUT;
                c.pc_write_cond = 1'b1;
            end
            S_JMP: begin
                c.pc_source = PCSRC_JUMP;
                c.pc_write  = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                c.pc_source = PCSRC_TRAP;
                c.pc_write  = 1'b1;
            end
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_alu_dec.sv
// ALU operation and immediate-extension decode from the current state, opcode and funct.
module mc_ctrl_fsm_alu_dec
    import mc_ctrl_fsm_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl,
    output logic       ext_sel
);

    // Add with sign-extension everywhere except the R-type, I-type ALU and branch-compare states.
    always_comb begin
        alu_ctrl = ALU_ADD;
        ext_sel  = 1'b1;
        case (state)
            S_EX_R: begin
                case (funct)
                    F_ADD:   alu_ctrl = ALU_ADD;
                    F_SUB:   alu_ctrl = ALU_SUB;
                    F_AND:   alu_ctrl = ALU_AND;
                    F_OR:    alu_ctrl = ALU_OR;
                    F_SLT:   alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            S_EX_I: begin
                case (opcode)
                    OP_ADDI: alu_ctrl = ALU_ADD;
                    OP_SLTI: alu_ctrl = ALU_SLT;
                    OP_ANDI: begin
                        alu_ctrl = ALU_AND;
                        ext_sel  = 1'b0;
                    end
                    OP_ORI: begin
                        alu_ctrl = ALU_OR;
                        ext_sel  = 1'b0;
                    end
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            S_BEQ:   alu_ctrl = ALU_SUB;
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM for the MIPS-subset core, with memory wait states and bus-error timeout.
// Define ILLEGAL_TRAP_EN to route unknown opcodes through the TRAP state and expose illegal_op.
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic [1:0] pc_source,
    output logic       ext_sel,
    output logic       bus_err,
    output logic [3:0] state
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic       illegal_op
`endif
);

`ifdef ILLEGAL_TRAP_EN
    localparam state_t ILLEGAL_NEXT = S_TRAP;
`else
    localparam state_t ILLEGAL_NEXT = S_IF;
`endif

    state_t           state_q;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout;
    ctrl_t            ctrl_q;
    logic             bus_err_q;
    logic             fetch_done;
    logic             unused_zero;
`ifdef ILLEGAL_TRAP_EN
    logic             illegal_q;
`endif

    // The branch decision is made in the datapath from pc_write_cond and zero.
    assign unused_zero = zero;

    // An IF cycle with mem_read low is a quiet cycle (after reset or a bus error) and never fetches.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = '0;
        timeout   = 1'b0;
        cnt_inc   = cnt_q + CNT_W'(1);
        case (state_q)
            S_IF, S_MRD, S_MWR: begin
                if (!(ctrl_q.mem_read | ctrl_q.mem_write)) begin
                    state_nxt = S_IF;
                end else if (mem_ready) begin
                    state_nxt = (state_q == S_IF)  ? S_ID  :
                                (state_q == S_MRD) ? S_MWB : S_IF;
                end else if (cnt_inc == CNT_W'(MEM_TIMEOUT)) begin
                    timeout   = 1'b1;
                    state_nxt = S_IF;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            S_ID: begin
                case (opcode)
                    OP_RTYPE:                         state_nxt = S_EX_R;
                    OP_LW, OP_SW:                     state_nxt = S_MA;
                    OP_BEQ:                           state_nxt = S_BEQ;
                    OP_J:                             state_nxt = S_JMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_nxt = S_EX_I;
                    default:                          state_nxt = ILLEGAL_NEXT;
                endcase
            end
            S_EX_R:  state_nxt = S_WB_R;
            S_EX_I:  state_nxt = S_WB_I;
            S_MA:    state_nxt = (opcode == OP_SW) ? S_MWR : S_MRD;
            default: state_nxt = S_IF;
        endcase
    end

    // A timeout lands in a quiet IF cycle with every enable low and bus_err high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IF;
            cnt_q     <= '0;
            ctrl_q    <= '0;
            bus_err_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            ctrl_q    <= timeout ? ctrl_t'('0) : decode_ctrl(state_nxt);
            bus_err_q <= timeout;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= (state_nxt == S_TRAP);
`endif
        end
    end

    assign fetch_done    = (state_q == S_IF) & ctrl_q.mem_read & mem_ready;
    assign ir_write      = fetch_done;
    assign pc_write      = ctrl_q.pc_write | fetch_done;
    assign pc_write_cond = ctrl_q.pc_write_cond;
    assign i_or_d        = ctrl_q.i_or_d;
    assign mem_read      = ctrl_q.mem_read;
    assign mem_write     = ctrl_q.mem_write;
    assign reg_dst       = ctrl_q.reg_dst;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign reg_write     = ctrl_q.reg_write;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign pc_source     = ctrl_q.pc_source;
    assign bus_err       = bus_err_q;
    assign state         = state_q;
`ifdef ILLEGAL_TRAP_EN
    assign illegal_op    = illegal_q;
`endif

    mc_ctrl_fsm_alu_dec u_alu_dec (
        .state    (state_q),
        .opcode   (opcode),
        .funct    (funct),
        .alu_ctrl (alu_ctrl),
        .ext_sel  (ext_sel)
    );

endmodule
